// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder. It computes a + b + cin over WIDTH bits, DIGIT bits per
// clock, starting at the LSB. The result is sum, carry-out and two's-complement
// overflow. Both sides use a valid/ready handshake.
//
// An accepted operation takes N = WIDTH/DIGIT compute cycles. The result is then
// held in DONE until the consumer takes it. Partial sums build up in an internal
// shift register. The sum port is loaded only when the last digit completes.
//
// Parameters
//   WIDTH     operand / sum width (>= 2)
//   DIGIT     bits added per cycle; must divide WIDTH
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  operands a, b, cin are valid
//   in_ready  block can accept operands (registered)
//   a, b      WIDTH-bit operands
//   cin       carry-in
//   out_valid sum, cout, ovf are valid (registered)
//   out_ready consumer accepts the result
//   sum       (a + b + cin) mod 2^WIDTH
//   cout      carry out of bit WIDTH-1
//   ovf       two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q,     state_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_sr_q,      a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,      b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q,    sum_sr_d;
  // The operand sign bits are shifted out of a_sr/b_sr before the overflow
  // decision. They are therefore captured separately when the operands are accepted.
  logic               a_msb_q,     a_msb_d;
  logic               b_msb_q,     b_msb_d;
  logic               carry_q,     carry_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic               cout_q,      cout_d;
  logic               ovf_q,       ovf_d;

  // {carry, digit} for the digit currently at the bottom of the shift registers
  logic [DIGIT:0]     digit_sum;

  // NOTE: every signal assigned in this block gets a default first. A branch
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    digit_sum = {1'b0, a_sr_q[DIGIT-1:0]} + {1'b0, b_sr_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};

    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = RUN;
          in_ready_d = 1'b0;
          a_sr_d     = a;
          b_sr_d     = b;
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
          carry_d    = cin;
          cnt_d      = '0;
        end
      end

      RUN: begin
        a_sr_d   = a_sr_q >> DIGIT;
        b_sr_d   = b_sr_q >> DIGIT;
        // The new digit enters at the MSB end. After N shifts the first
        // digit computed has reached bit 0.
        sum_sr_d = (sum_sr_q >> DIGIT)
                 | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d  = digit_sum[DIGIT];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          sum_d       = sum_sr_d;
          cout_d      = digit_sum[DIGIT];
          ovf_d       = (a_msb_q == b_msb_q) && (sum_sr_d[WIDTH-1] != a_msb_q);
        end
      end

      DONE: begin
        // A pending input is accepted at the next edge at the earliest,
        // because in_ready rises only after this edge.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only. Every flop then
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder with WIDTH=8. It instantiates four
// DIGIT variants: 1, 2, 4 and 8. Expected results come from an arithmetic
// reference model that uses integer addition and signed range checks.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;
  localparam int DIG [4] = '{1, 2, 4, 8};

  logic           clk;
  logic           rst;
  logic [3:0]     in_valid_v;
  logic [3:0]     out_ready_v;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           cin;
  logic [3:0]     in_ready_w;
  logic [3:0]     out_valid_w;
  logic [3:0]     cout_w;
  logic [3:0]     ovf_w;
  logic [W-1:0]   sum_w [4];

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));

  serial_adder #(.WIDTH(W), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));

  serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

  serial_adder #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_w[3]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_w[3]), .out_ready(out_ready_v[3]),
    .sum(sum_w[3]), .cout(cout_w[3]), .ovf(ovf_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Reference model: the sum as an integer, with cout taken from the ninth bit.
  // ovf is set when the signed result leaves the range of a signed byte.
  function automatic logic [9:0] ref_model(input logic [W-1:0] ra,
                                           input logic [W-1:0] rb,
                                           input logic rc);
    int u;
    int s;
    logic [9:0] r;
    u = int'(ra) + int'(rb) + int'(rc);
    s = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
    r[7:0] = 8'(u % 256);
    r[8]   = (u >= 256);
    r[9]   = (s > 127) || (s < -128);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (!in_ready_w[k] && n < 64) begin
      step();
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready_w[k]), 32'd1);
  endtask

  // Drive one operand set and return after the acceptance edge.
  task automatic accept(input int k, input logic [W-1:0] ai,
                        input logic [W-1:0] bi, input logic ci);
    a = ai;
    b = bi;
    cin = ci;
    in_valid_v[k] = 1'b1;
    step();
    in_valid_v[k] = 1'b0;
    // Scramble the operand bus. The block must ignore it while busy.
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    check("in_ready_after_accept", 32'(in_ready_w[k]), 32'd0);
  endtask

  // Count edges from acceptance to out_valid, then check the result.
  // While waiting, out_ready is toggled at random; it must have no effect outside DONE.
  task automatic wait_result(input int k, input logic [W-1:0] ai,
                             input logic [W-1:0] bi, input logic ci);
    int lat = 0;
    logic [9:0] exp_r;
    exp_r = ref_model(ai, bi, ci);
    do begin
      out_ready_v[k] = 1'($urandom);
      step();
      lat++;
    end while (!out_valid_w[k] && lat < 64);
    out_ready_v[k] = 1'b0;
    check("latency", 32'(lat), 32'(W / DIG[k]));
    check("sum",  32'(sum_w[k]),  32'(exp_r[7:0]));
    check("cout", 32'(cout_w[k]), 32'(exp_r[8]));
    check("ovf",  32'(ovf_w[k]),  32'(exp_r[9]));
  endtask

  task automatic consume(input int k, input logic [W-1:0] exp_sum);
    out_ready_v[k] = 1'b1;
    step();
    out_ready_v[k] = 1'b0;
    check("out_valid_after_consume", 32'(out_valid_w[k]), 32'd0);
    check("in_ready_after_consume",  32'(in_ready_w[k]),  32'd1);
    check("sum_kept_after_consume",  32'(sum_w[k]),       32'(exp_sum));
  endtask

  task automatic run_op(input int k, input logic [W-1:0] ai,
                        input logic [W-1:0] bi, input logic ci, input int stall);
    logic [9:0] exp_r;
    exp_r = ref_model(ai, bi, ci);
    wait_idle(k);
    accept(k, ai, bi, ci);
    wait_result(k, ai, bi, ci);
    repeat (stall) begin
      step();
      check("stall_out_valid", 32'(out_valid_w[k]), 32'd1);
      check("stall_sum",       32'(sum_w[k]),       32'(exp_r[7:0]));
    end
    consume(k, exp_r[7:0]);
  endtask

  initial begin
    logic [9:0] exp_r;
    in_valid_v  = '0;
    out_ready_v = '0;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state of every variant
    for (int k = 0; k < 4; k++) begin
      check("reset_in_ready",  32'(in_ready_w[k]),  32'd1);
      check("reset_out_valid", 32'(out_valid_w[k]), 32'd0);
      check("reset_sum",       32'(sum_w[k]),       32'd0);
      check("reset_cout",      32'(cout_w[k]),      32'd0);
      check("reset_ovf",       32'(ovf_w[k]),       32'd0);
    end

    // Basic, carry and overflow vectors at DIGIT=1
    run_op(0, 8'h00, 8'h01, 1'b0, 0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1);
    run_op(0, 8'h7F, 8'h01, 1'b0, 0);
    run_op(0, 8'h80, 8'h80, 1'b0, 2);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 0);

    // Backpressure: the result must be held while a new operand waits
    wait_idle(0);
    accept(0, 8'h3C, 8'h5A, 1'b1);
    wait_result(0, 8'h3C, 8'h5A, 1'b1);
    exp_r = ref_model(8'h3C, 8'h5A, 1'b1);
    a = 8'h81;
    b = 8'h82;
    cin = 1'b0;
    in_valid_v[0] = 1'b1;
    repeat (5) begin
      step();
      check("bp_sum",       32'(sum_w[0]),       32'(exp_r[7:0]));
      check("bp_cout",      32'(cout_w[0]),      32'(exp_r[8]));
      check("bp_ovf",       32'(ovf_w[0]),       32'(exp_r[9]));
      check("bp_in_ready",  32'(in_ready_w[0]),  32'd0);
      check("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
    end
    out_ready_v[0] = 1'b1;
    step();
    out_ready_v[0] = 1'b0;
    check("bp_in_ready_after_pulse",  32'(in_ready_w[0]),  32'd1);
    check("bp_out_valid_after_pulse", 32'(out_valid_w[0]), 32'd0);
    step();
    in_valid_v[0] = 1'b0;
    check("bp_new_accepted", 32'(in_ready_w[0]), 32'd0);
    wait_result(0, 8'h81, 8'h82, 1'b0);
    exp_r = ref_model(8'h81, 8'h82, 1'b0);
    consume(0, exp_r[7:0]);

    // Reset at RUN edge 3 discards the operation
    wait_idle(0);
    accept(0, 8'hAA, 8'h57, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_in_ready",  32'(in_ready_w[0]),  32'd1);
    check("rst_out_valid", 32'(out_valid_w[0]), 32'd0);
    check("rst_sum",       32'(sum_w[0]),       32'd0);
    check("rst_cout",      32'(cout_w[0]),      32'd0);
    check("rst_ovf",       32'(ovf_w[0]),       32'd0);
    repeat (3) begin
      step();
      check("rst_stays_idle", 32'(out_valid_w[0]), 32'd0);
    end
    run_op(0, 8'h12, 8'h34, 1'b0, 0);

    // Digit-width variants
    run_op(2, 8'hF0, 8'h1F, 1'b0, 0);
    run_op(3, 8'h7F, 8'h00, 1'b1, 1);

    // Random regression at DIGIT = 1, 2, 8
    foreach (DIG[k]) begin
      if (DIG[k] != 4) begin
        for (int i = 0; i < 1000; i++) begin
          run_op(k, W'($urandom), W'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
